// File: rtl/jtcps_dtack.sv
// jtcps_dtack -- DTACKn generator for a 68000-class CPU on SDRAM-backed CPS boards.
//
// Each of the CH chip-select channels has a minimum wait, counted in cen ticks,
// and its own SDRAM ready line. When a channel's wait has elapsed but its data
// is not ready yet, the extra clk ticks are added to a frame-scoped delay
// counter (fail_cnt). While fail_cnt is non-zero, later bus cycles on channels
// with a non-zero wait can acknowledge one cen tick early. Each early
// acknowledge pays back one tick of the accumulated delay.
//
// Optional build macro: JTCPS_DTACK_RECOVER_EN
//   defined   -> the early-acknowledge recovery path is built
//   undefined -> no recovery; fail_cnt only counts up and is cleared by frame
//
// Ports:
//   rst        async reset, active-high
//   clk        system clock
//   cen        CPU phi1 clock enable (advances the wait counter)
//   ASn        CPU address strobe, active-low
//   cs[CH]     registered chip selects, valid from the 2nd clk after ASn falls
//   ok[CH]     per-channel SDRAM data ready
//   frame      one-clk pulse at frame start
//   DTACKn     data acknowledge to the CPU (registered)
//   busy       some selected channel is not ready (based on registered ok)
//   fail_cnt   accumulated delay in clk ticks
//   last_fail  fail_cnt captured at the last frame pulse
//   ovf        sticky flag: fail_cnt saturated during the current frame

module jtcps_dtack #(
  parameter int                 CH   = 4,
  parameter int                 WW   = 3,
  parameter int                 FW   = 16,
  parameter logic [CH*WW-1:0]   WAIT = 12'h092
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          ASn,
  input  logic [CH-1:0] cs,
  input  logic [CH-1:0] ok,
  input  logic          frame,
  output logic          DTACKn,
  output logic          busy,
  output logic [FW-1:0] fail_cnt,
  output logic [FW-1:0] last_fail,
  output logic          ovf
);

  localparam logic [WW-1:0] CMAX = '1;
  localparam logic [FW-1:0] FMAX = '1;

  logic [CH-1:0] ok_r;
  logic          last_ASn;
  logic [WW-1:0] cnt;
  logic [WW-1:0] w;
  logic          edge_clk, active, met, inc, recover;

  // The first clk with ASn low is spent on the edge. cs is not valid yet.
  assign edge_clk = ~ASn & last_ASn;
  assign active   = ~ASn & ~last_ASn;

  // Descending scan, so the lowest set chip select decides the wait
  always_comb begin
    w = '0;
    for (int i = CH-1; i >= 0; i--)
      if (cs[i]) w = WAIT[i*WW +: WW];
  end

  assign busy = |(cs & ~ok_r);
  assign met  = cnt >= w;
  assign inc  = active && (|cs) && DTACKn && met && busy;

`ifdef JTCPS_DTACK_RECOVER_EN
  // Acknowledge one cen tick early to pay back accumulated lateness. DTACKn
  // then stays low until ASn rises, so this fires at most once per bus cycle.
  assign recover = active && (|cs) && DTACKn && !busy && !met &&
                   (fail_cnt != '0) && (w != '0) && (cnt == w - 1'b1);
`else
  assign recover = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_r     <= '0;
      last_ASn <= 1'b1;
    end else begin
      ok_r     <= ok;
      last_ASn <= ASn;
    end
  end

  // Wait counter: counts cen ticks inside a bus cycle and saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (ASn || edge_clk)     cnt <= '0;
    else if (cen && cnt != CMAX)  cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           DTACKn <= 1'b1;
    else if (ASn || edge_clk)          DTACKn <= 1'b1;
    else if (cs == '0)                 DTACKn <= 1'b0;  // unmapped access, acknowledge at once
    else if (DTACKn && ((!busy && met) || recover))
                                       DTACKn <= 1'b0;
  end

  // Delay statistics. The frame pulse wins over a same-clk update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt  <= '0;
      last_fail <= '0;
      ovf       <= 1'b0;
    end else if (frame) begin
      last_fail <= fail_cnt;
      fail_cnt  <= '0;
      ovf       <= 1'b0;
    end else if (inc) begin
      if (fail_cnt != FMAX) fail_cnt <= fail_cnt + 1'b1;
      // Flag as soon as the counter reaches its ceiling
      if (fail_cnt == FMAX || fail_cnt == FMAX - 1'b1) ovf <= 1'b1;
    end else if (recover) begin
      fail_cnt <= fail_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_jtcps_dtack.sv
// tb_jtcps_dtack -- directed bench for jtcps_dtack. Two instances share the
// stimulus: the default configuration and one with FW=4 for saturation.
// At the start of each bus cycle, the expected acknowledge clk and fail_cnt are
// queued. They are popped and compared when DTACKn falls.
module tb_jtcps_dtack;

`ifdef JTCPS_DTACK_RECOVER_EN
  localparam int REC = 1;
`else
  localparam int REC = 0;
`endif

  logic        rst, clk, cen, ASn, frame;
  logic [3:0]  cs, ok;
  logic        DTACKn, busy, ovf;
  logic [15:0] fail_cnt, last_fail;
  logic        DTACKn4, busy4, ovf4;
  logic [3:0]  fail4, last_fail4;

  jtcps_dtack u_dut (
    .rst(rst), .clk(clk), .cen(cen), .ASn(ASn), .cs(cs), .ok(ok), .frame(frame),
    .DTACKn(DTACKn), .busy(busy), .fail_cnt(fail_cnt), .last_fail(last_fail), .ovf(ovf)
  );

  jtcps_dtack #(.FW(4)) u_dut4 (
    .rst(rst), .clk(clk), .cen(cen), .ASn(ASn), .cs(cs), .ok(ok), .frame(frame),
    .DTACKn(DTACKn4), .busy(busy4), .fail_cnt(fail4), .last_fail(last_fail4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { string tag; int k; int fail; } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;
  int k;
  bit acked;
  logic [3:0] cs_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_cycle(input string tag, input logic [3:0] cs_v, input int ek, input int ef);
    exp_t e;
    e.tag = tag; e.k = ek; e.fail = ef;
    sb.push_back(e);
    k = 0; acked = 0; cs_r = cs_v;
  endtask

  // One clk inside the bus cycle. cen fires on every 4th clk after ASn falls.
  task automatic step(input logic [3:0] ok_v, input logic fr);
    exp_t e;
    k++;
    ASn = 1'b0; cs = cs_r; cen = (k % 4 == 0); ok = ok_v; frame = fr;
    tick();
    if (!acked && DTACKn == 1'b0) begin
      acked = 1;
      e = sb.pop_front();
      chk({e.tag, "_ack_clk"}, k, e.k);
      chk({e.tag, "_fail"}, fail_cnt, e.fail);
    end
  endtask

  // Run until the acknowledge arrives or 40 clks elapse. ok switches at clk K.
  // One extra clk then confirms that DTACKn holds low.
  task automatic run_rest(input string tag, input logic [3:0] ok0, input logic [3:0] ok1, input int K);
    while (!acked && k < 40) step((k + 1 >= K) ? ok1 : ok0, 1'b0);
    if (!acked) begin
      checks++; failures++;
      void'(sb.pop_front());
      $error("FAIL %s_timeout observed=no_ack expected=ack", tag);
    end else begin
      step(ok1, 1'b0);
      chk({tag, "_hold"}, DTACKn, 1'b0);
    end
  endtask

  task automatic end_cycle();
    ASn = 1'b1; cs = 4'h0; cen = 1'b0; frame = 1'b0;
    tick(); tick();
    chk("idle_dtack", DTACKn, 1'b1);
  endtask

  task automatic run_cycle(input string tag, input logic [3:0] cs_v, input logic [3:0] ok0,
                           input logic [3:0] ok1, input int K, input int ek, input int ef);
    start_cycle(tag, cs_v, ek, ef);
    run_rest(tag, ok0, ok1, K);
    end_cycle();
  endtask

  task automatic pulse_frame();
    frame = 1'b1; tick(); frame = 1'b0; tick();
  endtask

  initial begin
    int f;
    rst = 1'b1; ASn = 1'b1; cs = 4'h0; ok = 4'hF; cen = 1'b0; frame = 1'b0;
    tick(); tick();
    chk("rst_dtack", DTACKn, 1'b1);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_last", last_fail, 0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0; tick(); tick();

    // ok ready throughout: acknowledge on the clk after cnt reaches 2
    run_cycle("ch0_ready", 4'b0001, 4'hF, 4'hF, 99, 9, 0);
    // ok late: 5 clks past met plus the ok_r clk adds 6 ticks
    run_cycle("ch0_late", 4'b0001, 4'h0, 4'hF, 14, 15, 6);
    pulse_frame();
    chk("frame1_last", last_fail, 6);
    chk("frame1_fail", fail_cnt, 0);
    chk("frame1_last4", last_fail4, 6);

    run_cycle("ch0_late3", 4'b0001, 4'h0, 4'hF, 11, 12, 3);
    f = REC ? 2 : 3;
    run_cycle("ch0_recover", 4'b0001, 4'hF, 4'hF, 99, REC ? 5 : 9, f);
    // Zero wait: no early path, and fail_cnt is untouched
    run_cycle("ch3_zero", 4'b1000, 4'hF, 4'hF, 99, 2, f);
    run_cycle("no_cs", 4'b0000, 4'hF, 4'hF, 99, 2, f);

    // ch1 decides the wait, ch2 is not ready yet
    start_cycle("multi_cs", 4'b0110, 11, f + 2);
    for (int i = 0; i < 5; i++) step(4'b0010, 1'b0);
    chk("multi_busy", busy, 1'b1);
    chk("multi_dtack_hi", DTACKn, 1'b1);
    run_rest("multi_cs", 4'b0010, 4'b0110, 10);
    end_cycle();
    pulse_frame();
    chk("frame2_last", last_fail, f + 2);

    // FW=4 saturation, then frame on the same clk as an increment
    start_cycle("sat", 4'b0001, 31, 1);
    for (int i = 0; i < 28; i++) step(4'h0, 1'b0);
    chk("sat_fail4", fail4, 15);
    chk("sat_ovf4", ovf4, 1'b1);
    chk("sat_fail16", fail_cnt, 20);
    chk("sat_ovf16", ovf, 1'b0);
    step(4'h0, 1'b1);
    chk("frm_fail4", fail4, 0);
    chk("frm_last4", last_fail4, 15);
    chk("frm_ovf4", ovf4, 1'b0);
    chk("frm_last16", last_fail, 20);
    run_rest("sat", 4'h0, 4'hF, 30);
    end_cycle();

    // Async reset while the cycle is acknowledged
    start_cycle("rst_mid", 4'b0000, 2, 1);
    step(4'hF, 1'b0); step(4'hF, 1'b0);
    chk("rst_mid_ack", acked, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_dtack", DTACKn, 1'b1);
    chk("rst_mid_fail", fail_cnt, 0);
    chk("rst_mid_last", last_fail, 0);
    tick();
    ASn = 1'b1; rst = 1'b0; tick(); tick();
    chk("rst_after_dtack", DTACKn, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop so that the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
